tone_sample_feeder: RTL and testbench

//  Downstream of the note generator: turns its square-wave note_clock into signed 24-bit PCM samples.

---
 rtl/tone_sample_feeder_if.sv | 10 +
 rtl/tone_sample_feeder.sv | 125 ++++++++++++
 tb/tb_tone_sample_feeder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sample_feeder_if.sv
// Codec write port: push strobe, ready, and the stereo sample pair.
interface tone_sample_feeder_if;
   logic        write;
   logic        write_ready;
   logic [23:0] writedata_left;
   logic [23:0] writedata_right;

   modport master (output write, writedata_left, writedata_right, input write_ready);
   modport slave  (input write, writedata_left, writedata_right, output write_ready);
endinterface

// File: rtl/tone_sample_feeder.sv
// Turns the synchronized note square wave into enveloped signed PCM pushes to the codec.
// Optional STEREO_PAN_EN adds a pan[1:0] input selecting per-channel level.
module tone_sample_feeder #(
   parameter logic [22:0] AMP_MAX      = 23'h400000,
   parameter logic [22:0] ATTACK_STEP  = 23'd4096,
   parameter logic [22:0] RELEASE_STEP = 23'd1024,
   parameter int          GAP          = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        note_clock,
   input  logic                        note_active,
`ifdef STEREO_PAN_EN
   input  logic [1:0]                  pan,
`endif
   tone_sample_feeder_if.master        codec,
   output logic [22:0]                 env_level
);

   typedef enum logic [1:0] {WAIT, PUSH, HOLD} state_t;

   localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   state_t      state;
   logic [3:0]  gap_cnt;
   logic        note_meta;
   logic        note_s;
   logic [23:0] sample;
   logic [23:0] half;
   logic [23:0] sum_att;
   logic [23:0] left_n;
   logic [23:0] right_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         note_meta <= 1'b0;
         note_s    <= 1'b0;
      end else begin
         note_meta <= note_clock;
         note_s    <= note_meta;
      end
   end

   // 24-bit sum keeps the attack carry visible so saturation never wraps.
   assign sum_att = {1'b0, env_level} + {1'b0, ATTACK_STEP};

   always_comb begin
      sample = 24'd0;
      if (env_level != 23'd0) begin
         if (note_s)
            sample = {1'b0, env_level};
         else
            sample = ~{1'b0, env_level} + 24'd1;
      end
   end

   assign half = 24'($signed(sample) >>> 1);

   always_comb begin
      left_n  = sample;
      right_n = sample;
`ifdef STEREO_PAN_EN
      case (pan)
         2'b01:   right_n = 24'd0;
         2'b10:   left_n  = 24'd0;
         2'b11: begin
            left_n  = half;
            right_n = half;
         end
         default: ;
      endcase
`else
      if (half[0]) left_n = sample;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                 <= WAIT;
         gap_cnt               <= 4'd0;
         env_level             <= 23'd0;
         codec.write           <= 1'b0;
         codec.writedata_left  <= 24'd0;
         codec.writedata_right <= 24'd0;
      end else begin
         case (state)
            WAIT: begin
               codec.write <= 1'b0;
               if (enable && codec.write_ready) begin
                  codec.writedata_left  <= left_n;
                  codec.writedata_right <= right_n;
                  codec.write           <= 1'b1;
                  state                 <= PUSH;
               end
            end
            PUSH: begin
               codec.write <= 1'b0;
               if (note_active)
                  env_level <= (sum_att > {1'b0, AMP_MAX}) ? AMP_MAX : sum_att[22:0];
               else
                  env_level <= (env_level < RELEASE_STEP) ? 23'd0 : env_level - RELEASE_STEP;
               if (GAP == 0) begin
                  state <= WAIT;
               end else begin
                  gap_cnt <= GAP_LOAD;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               codec.write <= 1'b0;
               if (gap_cnt == 4'd0)
                  state <= WAIT;
               else
                  gap_cnt <= gap_cnt - 4'd1;
            end
            default: begin
               codec.write <= 1'b0;
               state       <= WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_sample_feeder.sv
// Randomized scoreboard bench for tone_sample_feeder with a behavioural envelope/sample model.
module tb_tone_sample_feeder;

   localparam int AMP = 4096;
   localparam int ATT = 1024;
   localparam int REL = 1024;
   localparam int GP  = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic note_clock = 1'b0;
   logic note_active = 1'b0;
   logic [22:0] env_level;
`ifdef STEREO_PAN_EN
   logic [1:0] pan = 2'b00;
`endif

   tone_sample_feeder_if bus ();

   tone_sample_feeder #(
      .AMP_MAX(23'd4096), .ATTACK_STEP(23'd1024), .RELEASE_STEP(23'd1024), .GAP(GP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .note_clock(note_clock),
      .note_active(note_active),
`ifdef STEREO_PAN_EN
      .pan(pan),
`endif
      .codec(bus),
      .env_level(env_level)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          env;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [23:0] obs_l[$];
   int          obs_c[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          wcount = 0;
   int          m_env = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a write is accepted whenever the feeder is idle and
   // enable&ready hold; it then stays busy for GAP+1 further edges.
   initial begin
      int   cool;
      bit   upd;
      logic np1, np2, ns;
      int   s, sl, sr;
      exp_t e;
      cool = 0; upd = 0; np1 = 0; np2 = 0;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_env = 0; cool = 0; upd = 0; np1 = 0; np2 = 0;
            sb_q.delete();
         end else begin
            cyc++;
            if (upd) begin
               if (note_active) m_env = (m_env + ATT > AMP) ? AMP : m_env + ATT;
               else             m_env = (m_env < REL) ? 0 : m_env - REL;
               upd = 0;
            end
            ns = np2;
            np2 = np1;
            np1 = note_clock;
            if (cool > 0) begin
               cool--;
            end else if (enable && bus.write_ready) begin
               s = (m_env == 0) ? 0 : (ns ? m_env : -m_env);
               sl = s; sr = s;
`ifdef STEREO_PAN_EN
               if (pan == 2'b01) sr = 0;
               if (pan == 2'b10) sl = 0;
               if (pan == 2'b11) begin sl = s >>> 1; sr = s >>> 1; end
`endif
               e.l = 24'(sl); e.r = 24'(sr); e.env = m_env; e.cyc = cyc;
               sb_q.push_back(e);
               upd = 1;
               cool = GP + 1;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && bus.write) begin
            wcount++;
            obs_l.push_back(bus.writedata_left);
            obs_c.push_back(cyc);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got write=1, expected write=0");
            end else begin
               e = sb_q.pop_front();
               check("left", 32'(bus.writedata_left), 32'(e.l));
               check("right", 32'(bus.writedata_right), 32'(e.r));
               check("env_at_write", 32'(env_level), 32'(e.env));
               check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic wait_obs(input int n, input int budget);
      int k;
      k = 0;
      while (obs_l.size() < n && k < budget) begin
         @(posedge clock);
         #2;
         k++;
      end
      if (obs_l.size() < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_obs: got %0d writes, expected %0d", obs_l.size(), n);
      end
   endtask

   initial begin
      logic [23:0] exp_up [6];
      logic [23:0] exp_dn [6];
      int          snap;
      int          k;
      exp_up = '{24'd0, 24'd1024, 24'd2048, 24'd3072, 24'd4096, 24'd4096};
      exp_dn = '{24'hFFF000, 24'hFFF400, 24'hFFF800, 24'hFFFC00, 24'd0, 24'd0};
      bus.write_ready = 1'b0;

      tick(3);
      @(negedge clock);
      check("reset_write", 32'(bus.write), 32'd0);
      check("reset_left", 32'(bus.writedata_left), 32'd0);
      check("reset_right", 32'(bus.writedata_right), 32'd0);
      check("reset_env", 32'(env_level), 32'd0);

      // Attack ramp with a held positive note.
      @(posedge clock); #2;
      reset = 1'b0; enable = 1'b1; bus.write_ready = 1'b1; note_active = 1'b1; note_clock = 1'b1;
      wait_obs(6, 200);
      for (int i = 0; i < 6; i++)
         if (i < obs_l.size()) check("attack_sample", 32'(obs_l[i]), 32'(exp_up[i]));
      if (obs_c.size() >= 2) check("write_spacing", 32'(obs_c[1] - obs_c[0]), 32'd5);

      // Negative half-wave then release to zero.
      note_clock = 1'b0; note_active = 1'b0;
      obs_l.delete(); obs_c.delete();
      wait_obs(6, 200);
      for (int i = 0; i < 6; i++)
         if (i < obs_l.size()) check("release_sample", 32'(obs_l[i]), 32'(exp_dn[i]));

      // Long stall on write_ready.
      bus.write_ready = 1'b0;
      snap = wcount;
      tick(50);
      check("stall_writes", 32'(wcount - snap), 32'd0);
      check("stall_env", 32'(env_level), 32'(m_env));
      note_active = 1'b1; note_clock = 1'b1; bus.write_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("resume_write", 32'(bus.write), 32'd1);

      // Reset in the middle of a push.
      tick(8);
      k = 0;
      do begin
         @(posedge clock); #1;
         k++;
      end while (!bus.write && k < 20);
      check("push_seen", 32'(bus.write), 32'd1);
      reset = 1'b1;
      #1;
      check("midpush_write", 32'(bus.write), 32'd0);
      check("midpush_left", 32'(bus.writedata_left), 32'd0);
      check("midpush_right", 32'(bus.writedata_right), 32'd0);
      check("midpush_env", 32'(env_level), 32'd0);
      @(posedge clock); #2;
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         enable          = ($urandom_range(0, 9) < 8);
         bus.write_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) note_active = ~note_active;
         if ($urandom_range(0, 9) < 3) note_clock = ~note_clock;
`ifdef STEREO_PAN_EN
         if ($urandom_range(0, 15) == 0) pan = 2'($urandom_range(0, 3));
`endif
         tick(1);
      end
      enable = 1'b0;
      tick(20);
      check("drain", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
